// File: rtl/debug_pkg.sv
// Shared types and defaults for the debug output-conditioning stage.
// Also provides the timer-width helper used by the LED stretcher.
package debug_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_LEVEL, S_GAP} led_state_e;

  localparam int LED_HOLD_DEF = 2_000_000;
  localparam int LED_GAP_DEF  = 1_000_000;

  // Wide enough to hold max(hold, gap) - 1; never narrower than one bit.
  function automatic int tmr_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/debug_sync_edge.sv
// Multi-flop synchroniser for one asynchronous bit, followed by an edge detector.
// level_o is the synchronised level; rise_o/fall_o are single-cycle strobes.
module debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/debug_led_stretcher.sv
// Conditions the debug mux outputs: stretches the LED status bit into a visible pulse with
// minimum on/off times, and flags/counts rising edges on each DEBUG_SIG bit.
module debug_led_stretcher
  import debug_pkg::*;
#(
  parameter int HOLD_CYCLES = LED_HOLD_DEF,
  parameter int GAP_CYCLES  = LED_GAP_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic               clk_20mhz,
  input  logic               rst_n_20mhz,
  input  logic               led_in,
  input  logic [7:0]         led_sel,
  input  logic [3:0]         dbg_in,
  input  logic               dbg_clr,
  output logic               led_out,
  output logic               led_busy,
  output logic [3:0]         dbg_sticky,
  output logic [4*CNT_W-1:0] dbg_cnt
);

  localparam int TMR_W = tmr_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic             led_level, led_rise, led_fall;
  led_state_e       state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             pend_q;
  logic [7:0]       sel_q;

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_led_sync (
    .clk_i   (clk_20mhz),
    .rst_ni  (rst_n_20mhz),
    .async_i (led_in),
    .level_o (led_level),
    .rise_o  (led_rise),
    .fall_o  (led_fall)
  );

  always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
    if (!rst_n_20mhz) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      pend_q   <= 1'b0;
      sel_q    <= '0;
      led_out  <= 1'b0;
      led_busy <= 1'b0;
    end else begin
      sel_q <= led_sel;
      // A new select code drops any in-flight event from the previous source.
      if (led_sel != sel_q) begin
        state_q  <= S_IDLE;
        tmr_q    <= '0;
        pend_q   <= 1'b0;
        led_out  <= 1'b0;
        led_busy <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (led_rise) begin
              state_q  <= S_ON;
              tmr_q    <= HOLD_LOAD;
              led_out  <= 1'b1;
              led_busy <= 1'b1;
            end
          end
          S_ON: begin
            if (tmr_q == '0) begin
              if (led_level) begin
                state_q <= S_LEVEL;
              end else begin
                state_q <= S_GAP;
                tmr_q   <= GAP_LOAD;
                led_out <= 1'b0;
              end
            end else begin
              tmr_q <= tmr_q - TMR_W'(1);
            end
          end
          S_LEVEL: begin
            if (led_fall || !led_level) begin
              state_q <= S_GAP;
              tmr_q   <= GAP_LOAD;
              led_out <= 1'b0;
            end
          end
          S_GAP: begin
            if (tmr_q == '0) begin
              pend_q <= 1'b0;
              if (pend_q || led_rise || led_level) begin
                state_q <= S_ON;
                tmr_q   <= HOLD_LOAD;
                led_out <= 1'b1;
              end else begin
                state_q  <= S_IDLE;
                led_busy <= 1'b0;
              end
            end else begin
              tmr_q <= tmr_q - TMR_W'(1);
              if (led_rise) pend_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            pend_q   <= 1'b0;
            led_out  <= 1'b0;
            led_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dbg
      logic             rise, level_unused, fall_unused;
      logic             sticky_q, sticky_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (clk_20mhz),
        .rst_ni  (rst_n_20mhz),
        .async_i (dbg_in[gi]),
        .level_o (level_unused),
        .rise_o  (rise),
        .fall_o  (fall_unused)
      );

      // A clear coinciding with an edge keeps that edge as the first new count.
      always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (dbg_clr) begin
          sticky_d = rise;
          cnt_d    = rise ? CNT_W'(1) : '0;
        end else if (rise) begin
          sticky_d = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
        if (!rst_n_20mhz) begin
          sticky_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          sticky_q <= sticky_d;
          cnt_q    <= cnt_d;
        end
      end

      assign dbg_sticky[gi]               = sticky_q;
      assign dbg_cnt[gi*CNT_W +: CNT_W]   = cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_debug_led_stretcher.sv
// Directed bench for debug_led_stretcher with HOLD=10, GAP=5, SYNC=2, CNT_W=4.
module tb_debug_led_stretcher;

  logic        clk_20mhz = 1'b0;
  logic        rst_n_20mhz;
  logic        led_in;
  logic [7:0]  led_sel;
  logic [3:0]  dbg_in;
  logic        dbg_clr;
  logic        led_out;
  logic        led_busy;
  logic [3:0]  dbg_sticky;
  logic [15:0] dbg_cnt;

  int tests = 0;
  int fails = 0;

  debug_led_stretcher #(
    .HOLD_CYCLES (10),
    .GAP_CYCLES  (5),
    .SYNC_STAGES (2),
    .CNT_W       (4)
  ) dut (
    .clk_20mhz   (clk_20mhz),
    .rst_n_20mhz (rst_n_20mhz),
    .led_in      (led_in),
    .led_sel     (led_sel),
    .dbg_in      (dbg_in),
    .dbg_clr     (dbg_clr),
    .led_out     (led_out),
    .led_busy    (led_busy),
    .dbg_sticky  (dbg_sticky),
    .dbg_cnt     (dbg_cnt)
  );

  always #25 clk_20mhz = ~clk_20mhz;

  task automatic tick;
    @(posedge clk_20mhz);
    #1;
  endtask

  task automatic test_reset;
    rst_n_20mhz = 1'b1;
    led_in = 1'b0; led_sel = 8'h00; dbg_in = 4'h0; dbg_clr = 1'b0;
    #2 rst_n_20mhz = 1'b0;
    for (int i = 0; i < 5; i++) begin
      led_in  = i[0];
      dbg_in  = 4'(i + 1);
      led_sel = 8'(i);
      tick();
      tests++;
      if ({led_out, led_busy, dbg_sticky, dbg_cnt} !== 22'h0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: led_out=%b busy=%b sticky=%b cnt=%h, required all 0",
                 i, led_out, led_busy, dbg_sticky, dbg_cnt);
      end
    end
    led_in = 1'b0; dbg_in = 4'h0; led_sel = 8'h00;
    rst_n_20mhz = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({led_out, led_busy, dbg_sticky, dbg_cnt} !== 22'h0) begin
        fails++;
        $display("FAIL reset_release cyc%0d: led_out=%b busy=%b sticky=%b cnt=%h, required all 0",
                 i, led_out, led_busy, dbg_sticky, dbg_cnt);
      end
    end
  endtask

  // Single-cycle pulse: on for post-edges n+2..n+11, busy through the gap to n+16.
  task automatic test_pulse;
    logic exp_led, exp_busy;
    led_sel = 8'h09;
    tick(); tick();
    led_in = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      exp_led  = (k >= 2 && k <= 11);
      exp_busy = (k >= 2 && k <= 16);
      tests++;
      if (led_out !== exp_led || led_busy !== exp_busy) begin
        fails++;
        $display("FAIL pulse k=%0d: led_out=%b busy=%b, required led_out=%b busy=%b",
                 k, led_out, led_busy, exp_led, exp_busy);
      end
      led_in = 1'b0;
    end
  endtask

  // Held level for 30 cycles, then a pulse during the gap re-arms the LED at gap expiry.
  task automatic test_level;
    logic exp_led;
    led_in = 1'b1;
    for (int k = 0; k < 51; k++) begin
      tick();
      exp_led = (k >= 2 && k <= 31) || (k >= 37 && k <= 46);
      tests++;
      if (led_out !== exp_led) begin
        fails++;
        $display("FAIL level k=%0d: led_out=%b, required %b", k, led_out, exp_led);
      end
      led_in = (k < 29) || (k == 32);
    end
    for (int i = 0; i < 8; i++) tick();
    tests++;
    if (led_busy !== 1'b0) begin
      fails++;
      $display("FAIL level_idle: busy=%b, required 0", led_busy);
    end
  endtask

  // Select change on the 4th S_ON cycle, with a coincident rise that must be ignored.
  task automatic test_sel_change;
    logic exp_on;
    led_in = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick();
      exp_on = (k >= 2 && k <= 5);
      tests++;
      if (led_out !== exp_on || led_busy !== exp_on) begin
        fails++;
        $display("FAIL sel_change k=%0d: led_out=%b busy=%b, required both %b",
                 k, led_out, led_busy, exp_on);
      end
      led_in  = (k == 3);
      led_sel = (k >= 5) ? 8'h0A : 8'h09;
    end
  endtask

  task automatic test_dbg;
    for (int e = 0; e < 20; e++) begin
      dbg_in = 4'b0100; tick();
      dbg_in = 4'b0000; tick();
      if (e == 4) begin
        tick(); tick();
        tests++;
        if (dbg_cnt !== 16'h0500) begin
          fails++;
          $display("FAIL dbg_count5: cnt=%h, required 0500", dbg_cnt);
        end
      end
    end
    tick(); tick();
    tests++;
    if (dbg_cnt !== 16'h0F00 || dbg_sticky !== 4'b0100) begin
      fails++;
      $display("FAIL dbg_saturate: cnt=%h sticky=%b, required 0f00 0100", dbg_cnt, dbg_sticky);
    end
    dbg_clr = 1'b1; tick();
    dbg_clr = 1'b0;
    tests++;
    if (dbg_cnt !== 16'h0000 || dbg_sticky !== 4'b0000) begin
      fails++;
      $display("FAIL dbg_clear: cnt=%h sticky=%b, required 0000 0000", dbg_cnt, dbg_sticky);
    end
    dbg_in = 4'b1111; tick();
    dbg_in = 4'b0000; tick();
    for (int i = 0; i < 2; i++) begin
      dbg_in = 4'b0100; tick();
      dbg_in = 4'b0000; tick();
    end
    tick(); tick();
    tests++;
    if (dbg_cnt !== 16'h1311 || dbg_sticky !== 4'b1111) begin
      fails++;
      $display("FAIL dbg_multi: cnt=%h sticky=%b, required 1311 1111", dbg_cnt, dbg_sticky);
    end
    dbg_in = 4'b0100; tick();
    dbg_in = 4'b0000; tick();
    dbg_clr = 1'b1; tick();
    dbg_clr = 1'b0;
    tests++;
    if (dbg_cnt !== 16'h0100 || dbg_sticky !== 4'b0100) begin
      fails++;
      $display("FAIL dbg_clr_edge: cnt=%h sticky=%b, required 0100 0100", dbg_cnt, dbg_sticky);
    end
  endtask

  task automatic test_reset_mid;
    logic exp_led;
    led_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      led_in = 1'b0;
    end
    tests++;
    if (led_out !== 1'b1) begin
      fails++;
      $display("FAIL mid_on: led_out=%b, required 1", led_out);
    end
    #10 rst_n_20mhz = 1'b0;
    #1;
    tests++;
    if (led_out !== 1'b0 || led_busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: led_out=%b busy=%b, required 0 0", led_out, led_busy);
    end
    tick();
    rst_n_20mhz = 1'b1;
    tick(); tick(); tick();
    led_in = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      exp_led = (k >= 2 && k <= 11);
      tests++;
      if (led_out !== exp_led) begin
        fails++;
        $display("FAIL post_reset k=%0d: led_out=%b, required %b", k, led_out, exp_led);
      end
      led_in = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_level();
    test_sel_change();
    test_dbg();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
